// File: rtl/nand_rst_pkg.sv
// Shared definitions for the NAND PHY reset sequencer.
//   rst_state_t : sequencer state, encoded exactly as presented on state_o
//                 (0=WAIT, 1=RELEASE, 2=RUN, 3=SOFT).
//   cnt_width() : bit width needed to hold values 0..max_val inclusive.
package nand_rst_pkg;

  typedef enum logic [1:0] {
    ST_WAIT    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2,
    ST_SOFT    = 2'd3
  } rst_state_t;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/nand_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input level
//   q     : input level re-timed to clk, two cycles of latency
module nand_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      // stage 0: may go metastable; stage 1: settled copy
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/nand_reset_sequencer.sv
// Reset sequencer for the NAND PHY. Waits until MMCM lock and IDELAYCTRL
// ready have been high together for STABLE_CYCLES cycles, then releases the
// per-bus active-low resets one by one, STAGGER_CYCLES apart. Each channel
// can then be soft-reset through a 4-phase req/ack handshake.
//   clk0         : single clock, rising edge
//   rstn0        : asynchronous active-low reset
//   pll_locked   : MMCM LOCKED (asynchronous)
//   idelay_rdy   : IDELAYCTRL RDY (asynchronous)
//   soft_rst_req : per-channel soft reset request (level)
//   soft_rst_ack : per-channel soft reset done (level)
//   ch_rstn      : per-channel active-low reset to the controllers
//   all_rdy      : every channel out of reset and no soft reset active
//   timeout_err  : sticky, WAIT lasted TIMEOUT_CYCLES cycles
//   state_o      : 0=WAIT 1=RELEASE 2=RUN 3=SOFT
module nand_reset_sequencer
  import nand_rst_pkg::*;
#(
  parameter int NUM_CH          = 4,
  parameter int STABLE_CYCLES   = 256,
  parameter int STAGGER_CYCLES  = 16,
  parameter int SOFT_RST_CYCLES = 32,
  parameter int TIMEOUT_CYCLES  = 65535
) (
  input  logic              clk0,
  input  logic              rstn0,
  input  logic              pll_locked,
  input  logic              idelay_rdy,
  input  logic [NUM_CH-1:0] soft_rst_req,
  output logic [NUM_CH-1:0] soft_rst_ack,
  output logic [NUM_CH-1:0] ch_rstn,
  output logic              all_rdy,
  output logic              timeout_err,
  output logic [1:0]        state_o
);

  localparam int CNT_MAX_SS = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_SS > SOFT_RST_CYCLES) ? CNT_MAX_SS : SOFT_RST_CYCLES;
  localparam int CNT_W      = cnt_width(CNT_MAX);
  localparam int TMO_W      = cnt_width(TIMEOUT_CYCLES);
  localparam int IDX_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // The shared counter runs 0..N-1 inside each phase; the terminal value
  // marks the edge on which that phase's action happens.
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST    = CNT_W'(SOFT_RST_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST     = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX      = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH - 1);

  logic lock_s;
  logic rdy_s;
  logic cond;

  rst_state_t        state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [TMO_W-1:0]  tmo_cnt, tmo_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [NUM_CH-1:0] ch_nxt;
  logic [NUM_CH-1:0] ack_nxt;
  logic              rdy_nxt;
  logic              err_nxt;
  logic [NUM_CH-1:0] pending;
  logic [IDX_W-1:0]  sel;

  // input synchronisation
  nand_sync2 u_sync_lock (
    .clk   (clk0),
    .rst_n (rstn0),
    .d     (pll_locked),
    .q     (lock_s)
  );

  nand_sync2 u_sync_rdy (
    .clk   (clk0),
    .rst_n (rstn0),
    .d     (idelay_rdy),
    .q     (rdy_s)
  );

  assign cond = lock_s & rdy_s;

  // A request is pending until it has been acknowledged; a request left
  // high after its ack therefore never retriggers.
  assign pending = soft_rst_req & ~soft_rst_ack;

  always_comb begin
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pending[i]) sel = IDX_W'(i);
    end
  end

  // next-state and output decode
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tmo_nxt   = tmo_cnt;
    idx_nxt   = idx;
    ch_nxt    = ch_rstn;
    ack_nxt   = soft_rst_ack & soft_rst_req;
    rdy_nxt   = all_rdy;
    err_nxt   = timeout_err;

    if (state == ST_WAIT) begin
      if (tmo_cnt != TMO_MAX) tmo_nxt = tmo_cnt + TMO_W'(1);
      if (tmo_cnt == TMO_LAST) err_nxt = 1'b1;

      if (!cond) begin
        cnt_nxt = '0;
      end else if (cnt == STABLE_LAST) begin
        cnt_nxt   = '0;
        tmo_nxt   = '0;
        ch_nxt[0] = 1'b1;
        if (NUM_CH == 1) begin
          state_nxt = ST_RUN;
          rdy_nxt   = 1'b1;
        end else begin
          state_nxt = ST_RELEASE;
          idx_nxt   = IDX_W'(1);
        end
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end else if (!cond) begin
      // Lost lock/ready: drop everything and start over, abandoning any
      // soft reset in flight.
      state_nxt = ST_WAIT;
      cnt_nxt   = '0;
      idx_nxt   = '0;
      ch_nxt    = '0;
      ack_nxt   = '0;
      rdy_nxt   = 1'b0;
    end else begin
      case (state)
        ST_RELEASE: begin
          if (cnt == STAGGER_LAST) begin
            cnt_nxt     = '0;
            ch_nxt[idx] = 1'b1;
            idx_nxt     = idx + IDX_W'(1);
            if (idx == LAST_IDX) begin
              state_nxt = ST_RUN;
              rdy_nxt   = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (|pending) begin
            state_nxt   = ST_SOFT;
            cnt_nxt     = '0;
            idx_nxt     = sel;
            ch_nxt[sel] = 1'b0;
            rdy_nxt     = 1'b0;
          end
        end
        ST_SOFT: begin
          if (cnt == SOFT_LAST) begin
            state_nxt    = ST_RUN;
            cnt_nxt      = '0;
            ch_nxt[idx]  = 1'b1;
            ack_nxt[idx] = 1'b1;
            rdy_nxt      = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: begin
          state_nxt = ST_WAIT;
        end
      endcase
    end
  end

  // state and output registers
  always_ff @(posedge clk0 or negedge rstn0) begin
    if (!rstn0) begin
      state        <= ST_WAIT;
      cnt          <= '0;
      tmo_cnt      <= '0;
      idx          <= '0;
      ch_rstn      <= '0;
      soft_rst_ack <= '0;
      all_rdy      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      tmo_cnt      <= tmo_nxt;
      idx          <= idx_nxt;
      ch_rstn      <= ch_nxt;
      soft_rst_ack <= ack_nxt;
      all_rdy      <= rdy_nxt;
      timeout_err  <= err_nxt;
    end
  end

  assign state_o = state;

endmodule
